npu_host_seq: RTL and testbench

- Synthesizable host-side sequencer for the NPU's shared 32-bit we/oe/data bus. It replaces hand-timed bench stimulus with a reusable engine.
- It streams a load image (header, weights, biases, inputs) from an upstream valid/ready source into the NPU with `npu_we` asserted, then waits for `npu_ready`.
- It then pulses `npu_oe` to read back a configurable number of results and emits them on an output stream.
- Sits between a host/DMA word source and the `npu` top; also usable in benches as the NPU driver.

---
 rtl/npu_host_seq.sv | 179 +++++++++++++++++
 tb/tb_npu_host_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_host_seq.sv
// Host-side sequencer for the NPU shared we/oe/data bus: streams a load image in,
// waits for the NPU to finish, then reads back a programmable number of results.
module npu_host_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 13,
    parameter int unsigned OUT_W   = 6,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OUT_W-1:0]  num_out,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              npu_we,
    output logic              npu_oe,
    output logic [DATA_W-1:0] npu_data_o,
    output logic              npu_data_en,
    input  logic [DATA_W-1:0] npu_data_i,
    input  logic              npu_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  load_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StRead,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic              last_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  num_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [OUT_W-1:0]  issue_q;
    logic [OUT_W-1:0]  cap_q;
    logic [RD_LAT-1:0] pipe_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;

    logic start_ok;
    logic accept;
    logic capture;
    logic last_beat;

    assign start_ok  = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign accept    = s_valid && s_ready;
    // pipe_q tracks each oe cycle until its read data is due on npu_data_i
    assign capture   = pipe_q[RD_LAT-1];
    assign last_beat = capture && (cap_q == num_q - OUT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLoad;
            end
            // last_q marks the write cycle of the final word; WAIT follows it
            StLoad: begin
                if (last_q) state_d = StWait;
            end
            StWait: begin
                if (npu_ready) begin
                    state_d = (num_q == '0) ? StDone : StRead;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end
            end
            StRead: begin
                if (last_beat) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        s_ready = 1'b0;
        npu_oe  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            StLoad: begin
                s_ready = !last_q;
                busy    = 1'b1;
            end
            StWait: busy = 1'b1;
            StRead: begin
                npu_oe = (issue_q != num_q);
                busy   = 1'b1;
            end
            StDone: done = 1'b1;
            StErr:  err  = 1'b1;
            default: ;
        endcase
    end

    assign npu_we      = we_q;
    assign npu_data_en = we_q;
    assign npu_data_o  = data_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign load_cnt    = cnt_q;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b0;
            data_q    <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            num_q     <= '0;
            tmr_q     <= '0;
            issue_q   <= '0;
            cap_q     <= '0;
            pipe_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            we_q <= accept;
            if (accept) data_q <= s_data;

            if (start_ok) begin
                cnt_q   <= '0;
                num_q   <= num_out;
                last_q  <= 1'b0;
                issue_q <= '0;
                cap_q   <= '0;
            end else begin
                if (accept) begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                    if (s_last) last_q <= 1'b1;
                end else if (state_q == StLoad && last_q) begin
                    last_q <= 1'b0;
                end
                if (npu_oe)  issue_q <= issue_q + OUT_W'(1);
                if (capture) cap_q   <= cap_q + OUT_W'(1);
            end

            tmr_q <= (state_q == StWait && state_d == StWait) ? tmr_q + TMR_W'(1) : '0;

            pipe_q[0] <= npu_oe;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end

            m_valid_q <= capture;
            if (capture) m_data_q <= npu_data_i;
        end
    end

endmodule

// File: tb/tb_npu_host_seq.sv
// Randomized self-checking bench for npu_host_seq with a queue-based job model
// and a behavioural NPU that returns a result list in response to oe cycles.
module tb_npu_host_seq;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int OW = 6;
    localparam int TO = 16;
    localparam int RL = 1;
    localparam int CntMax = (1 << CW) - 1;
    // 2*1024 + 4096 = 6144.0 = 1.5 * 2^12 in IEEE-754 single precision
    localparam logic [31:0] SingleRes = {1'b0, 8'd139, 23'h400000};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [OW-1:0] num_out;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          npu_we;
    logic          npu_oe;
    logic [DW-1:0] npu_data_o;
    logic          npu_data_en;
    logic [DW-1:0] npu_data_i;
    logic          npu_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] load_cnt;

    npu_host_seq #(
        .DATA_W (DW),
        .CNT_W  (CW),
        .OUT_W  (OW),
        .TIMEOUT(TO),
        .RD_LAT (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_out    (num_out),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .npu_we     (npu_we),
        .npu_oe     (npu_oe),
        .npu_data_o (npu_data_o),
        .npu_data_en(npu_data_en),
        .npu_data_i (npu_data_i),
        .npu_ready  (npu_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_cnt   (load_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] res[$];
    logic [DW-1:0] wr_log[$];
    logic [DW-1:0] m_log[$];
    int            we_cnt, oe_cnt, oe_runs, excl_bad, hold_bad, res_idx;
    bit            prev_oe, oe_seen;
    logic [DW-1:0] last_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: logs writes, oe runs, results and protocol violations per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (npu_we === 1'b1) begin
                wr_log.push_back(npu_data_o);
                we_cnt++;
            end
            if (npu_oe === 1'b1) begin
                oe_cnt++;
                if (!prev_oe) oe_runs++;
            end
            prev_oe = (npu_oe === 1'b1);
            oe_seen = prev_oe;
            if (m_valid === 1'b1) m_log.push_back(m_data);
            if ((npu_we & npu_oe) === 1'b1 || (npu_data_en & npu_oe) === 1'b1 ||
                (done & err) === 1'b1 || (busy & (done | err)) === 1'b1) excl_bad++;
            if (busy === 1'b1 && npu_we === 1'b0 && npu_data_o !== last_data) hold_bad++;
            last_data = npu_data_o;
        end
    end

    // NPU read model: each oe cycle yields the next result one cycle later
    initial begin
        npu_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (oe_seen) begin
                npu_data_i = (res_idx < res.size()) ? res[res_idx] : '0;
                res_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        m_log.delete();
        we_cnt   = 0;
        oe_cnt   = 0;
        oe_runs  = 0;
        excl_bad = 0;
        hold_bad = 0;
        res_idx  = 0;
    endtask

    // gap: 0 = back-to-back, 1 = alternate idle cycles, 2 = random idle gaps
    task automatic stream(input int gap, input int upto);
        bit acc;
        int guard;
        for (int i = 0; i < upto; i++) begin
            if (gap == 1 && i > 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'b1;
                tick();
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 3)) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    s_last  = 1'($urandom);
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = src[i];
            s_last  = (i == src.size() - 1);
            guard   = 0;
            acc     = 1'b0;
            do begin
                @(negedge clk);
                acc = s_ready;
                tick();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) begin
                check_eq("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_job(input int nres, input int gap, input bit to_err,
                           input bit start_in_read, input int rdy_dly);
        int waits;
        int guard;
        int exp_cnt;
        clear_logs();
        npu_ready = 1'b0;
        num_out   = OW'(nres);
        start     = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("start_clr", {busy, done, err}, 3'b100);
        @(posedge clk);
        #1;
        stream(gap, src.size());
        if (!to_err) begin
            repeat (rdy_dly) tick();
            npu_ready = 1'b1;
        end
        if (start_in_read) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (npu_oe !== 1'b1 && guard < 100);
            @(posedge clk);
            #1;
            start   = 1'b1;
            num_out = '0;
            tick();
            start = 1'b0;
        end
        waits = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (busy && !s_ready && !npu_we && !npu_oe) waits++;
            guard++;
        end while (!(done === 1'b1 || err === 1'b1) && guard < 300);
        if (guard >= 300) check_eq("end_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);

        exp_cnt = (src.size() > CntMax) ? CntMax : src.size();
        check_eq("end_flags", {busy, done, err}, to_err ? 3'b001 : 3'b010);
        check_eq("we_cnt", we_cnt, src.size());
        for (int i = 0; i < wr_log.size() && i < src.size(); i++) begin
            check_eq("wr_data", wr_log[i], src[i]);
        end
        check_eq("load_cnt", load_cnt, exp_cnt);
        check_eq("oe_cnt", oe_cnt, to_err ? 0 : nres);
        check_eq("oe_runs", oe_runs, (!to_err && nres > 0) ? 1 : 0);
        check_eq("m_cnt", m_log.size(), to_err ? 0 : nres);
        for (int i = 0; i < m_log.size() && i < res.size(); i++) begin
            check_eq("m_data", m_log[i], res[i]);
        end
        check_eq("excl", excl_bad, 0);
        check_eq("hold", hold_bad, 0);
        if (to_err) check_eq("wait_cycles", waits, TO);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int nw, input int nr);
        src.delete();
        res.delete();
        for (int i = 0; i < nw; i++) src.push_back($urandom);
        for (int i = 0; i < nr; i++) res.push_back($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_out   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        npu_ready = 1'b0;
        clear_logs();
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out", {s_ready, npu_we, npu_oe, npu_data_en, m_valid, busy, done, err}, 8'd0);
        check_eq("rst_data", {npu_data_o, m_data}, 64'd0);
        check_eq("rst_cnt", load_cnt, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a load
        fill_random(10, 1);
        num_out = 1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        stream(0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid", {busy, npu_we, npu_oe, s_ready, done, err}, 6'd0);
        check_eq("rst_mid_cnt", load_cnt, 0);
        @(posedge clk);
        #1;

        // Single-neuron image, ready already high on WAIT entry
        src = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h40000000, 32'h45800000, 32'h44800000};
        res = '{SingleRes};
        run_job(1, 0, 1'b0, 1'b0, 0);

        // Source alternating valid/idle
        fill_random(6, 2);
        run_job(2, 1, 1'b0, 1'b0, 2);

        // Ready never comes: timeout into ERR
        fill_random(5, 0);
        run_job(0, 0, 1'b1, 1'b0, 0);

        // Five results, with an ignored start pulse during READ
        src.delete();
        for (int i = 0; i < 4; i++) src.push_back($urandom);
        res = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        run_job(5, 0, 1'b0, 1'b1, 3);

        // No results requested
        fill_random(4, 0);
        run_job(0, 0, 1'b0, 1'b0, 1);

        // Load counter saturation
        fill_random(20, 1);
        run_job(1, 0, 1'b0, 1'b0, 0);

        for (int j = 0; j < 6; j++) begin
            int nw;
            int nr;
            nw = $urandom_range(1, 12);
            nr = $urandom_range(0, 6);
            fill_random(nw, nr);
            run_job(nr, 2, 1'b0, 1'b0, $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
